rv32_writeback: RTL
===================

// Module: rv32_writeback
// PURPOSE
//  Writeback stage: sole producer of the register-file write port (rd_address/rd_value).
//  Takes ALU/link results from execute, or tracks one outstanding load to data memory.
//  Aligns and extends load data, then drives one write per retired instruction.
//  Drives rd_address=0 whenever no write is intended; the register file treats x0 writes as no-ops.
// PARAMETERS
//  LOAD_TIMEOUT  16  cycles in WAIT_LOAD without mem_rvalid before a load fault (>=1)
// PORTS
//  clk          in   1   clock; all state updates on posedge
//  reset_n      in   1   synchronous active-low reset
//  ex_valid     in   1   execute presents an instruction
//  ex_ready     out  1   writeback accepts; transfer when ex_valid&&ex_ready
//  ex_rd        in   5   destination register
//  ex_result    in   32  ALU/link result (non-load)
//  ex_is_load   in   1   instruction is a load
//  ex_funct3    in   3   load width/sign (LB,LH,LW,LBU,LHU)
//  ex_addr_lo   in   2   load byte address bits [1:0]
//  mem_rvalid   in   1   load data valid (single-cycle pulse)
//  mem_rdata    in   32  aligned memory word
//  mem_rerr     in   1   bus error, qualified by mem_rvalid
//  rd_address   out  5   register-file write address (0 = no write)
//  rd_value     out  32  register-file write data
//  retire       out  1   one-cycle pulse per completed instruction, including faults
//  load_fault   out  1   one-cycle pulse: bus error, timeout or illegal funct3
//  wb_busy      out  1   load outstanding (state==WAIT_LOAD)
// BEHAVIOUR
//  - All outputs except ex_ready are registered. Reset values: rd_address=0, rd_value=0,
//    retire=0, load_fault=0, wb_busy=0. State=IDLE, timer=0.
//  - Reset is synchronous and wins over every other event, including mid-load; the pending load is dropped.
//  - ex_ready = (state==IDLE). This is combinational from state only.
//  - Default each cycle: rd_address=0, retire=0, load_fault=0. rd_value holds its value.
//  - IDLE, non-load accept: next cycle rd_address=ex_rd, rd_value=ex_result, retire=1. Latency is 1.
//  - IDLE, load accept with funct3 in {3,6,7}: no write, next cycle retire=1 and load_fault=1. Stay in IDLE.
//  - IDLE, legal load accept: capture rd, funct3, addr_lo; timer=0; go to WAIT_LOAD.
//  - WAIT_LOAD: timer increments each cycle without mem_rvalid.
//    - mem_rvalid && !mem_rerr: next cycle rd_address=rd, rd_value=aligned data, retire=1; go to IDLE.
//    - mem_rvalid && mem_rerr: no write; retire=1, load_fault=1; go to IDLE.
//    - Timeout, i.e. timer==LOAD_TIMEOUT-1 with no rvalid: no write; retire=1, load_fault=1; go to IDLE.
//    - mem_rvalid in the same cycle as timer expiry: the data wins and is written normally.
//  - Load latency is the rvalid cycle +1. The earliest next accept is the cycle the write is visible.
//  - mem_rvalid while in IDLE is spurious and ignored (no write, no fault).
//  - rd==0 for any instruction: rd_address stays 0, retire still pulses.
//  - Alignment, with sh = addr_lo*8:
//    - LB: sign-extend byte (rdata>>sh)[7:0].
//    - LBU: zero-extend the same byte.
//    - LH/LHU: halfword (rdata>>{addr_lo[1],4'b0})[15:0], sign- or zero-extended; addr_lo[0] ignored.
//    - LW: rdata; addr_lo ignored.
//  - Timer width is $clog2(LOAD_TIMEOUT+1). It saturates and never wraps.
// STRUCTURE
//  - Shared package rv32_pkg:
//    - funct3 constants F3_LB=3'b000, F3_LH=3'b001, F3_LW=3'b010, F3_LBU=3'b100, F3_LHU=3'b101.
//    - Writeback state localparams WB_IDLE and WB_WAIT_LOAD.
//  - Sub-module rv32_load_align: combinational (funct3, addr_lo, rdata) -> 32-bit value plus illegal flag.
//    It is reusable by a future LSU.
// TESTING
//  - Reset held 3 cycles with ex_valid=1: rd_address=0, retire=0, ex_ready=1 after release.
//  - ALU: ex_rd=5, ex_result=32'hDEADBEEF accepted at cycle t -> at t+1 rd_address=5, rd_value=DEADBEEF, retire=1;
//    at t+2 rd_address=0.
//  - Loads with mem_rdata=32'h80FF7F01:
//    - LB addr_lo=3 -> FFFFFF80.
//    - LBU addr_lo=1 -> 0000007F.
//    - LH addr_lo=2 -> FFFF80FF.
//    - LHU addr_lo=0 -> 00007F01.
//    - LW -> 80FF7F01.
//    - Each is written one cycle after mem_rvalid, and ex_ready=0 throughout WAIT_LOAD.
//  - Faults, each giving load_fault=1 and retire=1 with rd_address=0:
//    - Load rd=7 with no rvalid for LOAD_TIMEOUT=16 cycles -> pulse on cycle 17.
//    - mem_rerr=1 -> pulse one cycle after rvalid.
//    - funct3=3'b011 -> pulse one cycle after accept.
//    - rvalid on exactly cycle 16 -> normal write instead of fault.
//  - reset_n low during WAIT_LOAD, then rvalid after release -> no write, no retire, state IDLE.
//  - Load with rd=0 -> retire pulses, rd_address stays 0.
//  - Spurious rvalid in IDLE -> no output change.

Source files
------------

// File: rtl/rv32_pkg.sv
// Shared RV32 core definitions: load funct3 codes,
// writeback state encoding and the captured-load context.
package rv32_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic {
    WB_IDLE      = 1'b0,
    WB_WAIT_LOAD = 1'b1
  } wb_state_t;

  typedef struct packed {
    logic [4:0] rd;
    logic [2:0] funct3;
    logic [1:0] addr_lo;
  } ld_ctx_t;

endpackage

// File: rtl/rv32_load_align.sv
// Load data alignment and sign/zero extension.
// Pure combinational so a future LSU can reuse it.
module rv32_load_align
  import rv32_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] value,
  output logic        illegal
);

  logic [7:0]  b;
  logic [15:0] h;

  assign b = rdata[{addr_lo, 3'b000} +: 8];
  assign h = rdata[{addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    value   = '0;
    illegal = 1'b0;
    unique case (1'b1)
      funct3 == F3_LB:  value = {{24{b[7]}}, b};
      funct3 == F3_LBU: value = {24'h0, b};
      funct3 == F3_LH:  value = {{16{h[15]}}, h};
      funct3 == F3_LHU: value = {16'h0, h};
      funct3 == F3_LW:  value = rdata;
      default:          illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/rv32_writeback.sv
// Writeback stage: sole driver of the register-file
// write port; retires ALU results and one outstanding load.
module rv32_writeback
  import rv32_pkg::*;
#(
  parameter int LOAD_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [4:0]  ex_rd,
  input  logic [31:0] ex_result,
  input  logic        ex_is_load,
  input  logic [2:0]  ex_funct3,
  input  logic [1:0]  ex_addr_lo,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rerr,
  output logic [4:0]  rd_address,
  output logic [31:0] rd_value,
  output logic        retire,
  output logic        load_fault,
  output logic        wb_busy
);

  localparam int TW = $clog2(LOAD_TIMEOUT + 1);
  localparam logic [TW-1:0] T_LAST = TW'(LOAD_TIMEOUT - 1);

  wb_state_t     state;
  logic [TW-1:0] timer;
  ld_ctx_t       ld;

  logic [2:0]  al_f3;
  logic [1:0]  al_lo;
  logic [31:0] al_value;
  logic        al_illegal;

  assign ex_ready = (state == WB_IDLE);

  // Idle: aligner checks the incoming funct3; waiting: it shapes load data.
  assign al_f3 = ex_ready ? ex_funct3  : ld.funct3;
  assign al_lo = ex_ready ? ex_addr_lo : ld.addr_lo;

  rv32_load_align u_align (
    .funct3  (al_f3),
    .addr_lo (al_lo),
    .rdata   (mem_rdata),
    .value   (al_value),
    .illegal (al_illegal)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= WB_IDLE;
      timer      <= '0;
      ld         <= '0;
      rd_address <= '0;
      rd_value   <= '0;
      retire     <= 1'b0;
      load_fault <= 1'b0;
      wb_busy    <= 1'b0;
    end else begin
      rd_address <= '0;
      retire     <= 1'b0;
      load_fault <= 1'b0;
      unique case (state)
        WB_IDLE: begin
          if (ex_valid) begin
            if (!ex_is_load) begin
              rd_address <= ex_rd;
              rd_value   <= ex_result;
              retire     <= 1'b1;
            end else if (al_illegal) begin
              retire     <= 1'b1;
              load_fault <= 1'b1;
            end else begin
              ld      <= '{rd: ex_rd,
                           funct3: ex_funct3,
                           addr_lo: ex_addr_lo};
              timer   <= '0;
              state   <= WB_WAIT_LOAD;
              wb_busy <= 1'b1;
            end
          end
        end
        WB_WAIT_LOAD: begin
          // Data arriving on the expiry cycle still wins.
          if (mem_rvalid) begin
            retire  <= 1'b1;
            state   <= WB_IDLE;
            wb_busy <= 1'b0;
            if (mem_rerr) begin
              load_fault <= 1'b1;
            end else begin
              rd_address <= ld.rd;
              rd_value   <= al_value;
            end
          end else if (timer == T_LAST) begin
            retire     <= 1'b1;
            load_fault <= 1'b1;
            state      <= WB_IDLE;
            wb_busy    <= 1'b0;
          end else begin
            timer <= timer + TW'(1);
          end
        end
      endcase
    end
  end

endmodule
